// File: rtl/ervp_txn_latency_probe.sv
// ervp_txn_latency_probe
// Passive observer of one in-order request/response channel. Request
// handshakes push a timestamp into a small FIFO. Last response beats pop the
// head entry and report how many cycles the transaction took. Strobes for the
// stall/latency watchdog monitor and debug status are derived from this FIFO.
module ervp_txn_latency_probe #(
    parameter int BW_TIME        = 16,
    parameter int DEPTH          = 4,
    parameter int BW_OUTSTANDING = 3
) (
    input  logic                      clk,
    input  logic                      rstnn,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      req_valid,
    input  logic                      req_ready,
    input  logic                      rsp_valid,
    input  logic                      rsp_ready,
    input  logic                      rsp_last,
    output logic                      monitor_init,
    output logic                      monitor_count,
    output logic                      latency_valid,
    output logic [BW_TIME-1:0]        latency,
    output logic [BW_OUTSTANDING-1:0] num_outstanding,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);

    // The extra pointer bit is a wrap flag, so equal indices with different
    // wrap flags mean full and identical pointers mean empty.
    localparam logic [AW:0]        PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]        DEPTH_CNT = DEPTH[AW:0];
    localparam logic [BW_TIME-1:0] TS_ONE    = {{(BW_TIME-1){1'b0}}, 1'b1};

    logic [BW_TIME-1:0]        r_ts;
    logic [BW_TIME-1:0]        r_mem [DEPTH];
    logic [AW:0]               r_wptr;
    logic [AW:0]               r_rptr;

    logic                      r_monitor_init;
    logic                      r_monitor_count;
    logic                      r_latency_valid;
    logic [BW_TIME-1:0]        r_latency;
    logic [BW_OUTSTANDING-1:0] r_num_outstanding;
    logic                      r_overflow;
    logic                      r_underflow;

    logic [AW:0]               w_count;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_push_req;
    logic                      w_pop_req;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_overflow_evt;
    logic                      w_underflow_evt;
    logic [AW:0]               w_next_count;
    logic [BW_TIME-1:0]        w_head_latency;

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (w_count == {(AW+1){1'b0}});
    assign w_full    = (w_count == DEPTH_CNT);

    assign w_push_req = enable & req_valid & req_ready;
    assign w_pop_req  = enable & rsp_valid & rsp_ready & rsp_last;

    // A pop only sees entries written in earlier cycles, so an empty FIFO
    // rejects the pop even if a push lands in the same cycle.
    assign w_pop           = w_pop_req & ~w_empty;
    assign w_underflow_evt = w_pop_req & w_empty;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push          = w_push_req & (~w_full | w_pop);
    assign w_overflow_evt  = w_push_req & w_full & ~w_pop;

    // Modular subtraction gives the latency across timestamp wrap.
    assign w_head_latency  = r_ts - r_mem[r_rptr[AW-1:0]];

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        w_next_count = w_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = w_count + PTR_ONE;
            2'b01:   w_next_count = w_count - PTR_ONE;
            default: w_next_count = w_count;
        endcase
    end

    // Free-running timestamp; independent of enable and clear.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Request timestamp storage, written at the write pointer on each push.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !clear) begin
            r_mem[r_wptr[AW-1:0]] <= r_ts;
        end
    end

    // FIFO pointers; clear empties the FIFO ahead of any handshake.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Registered strobes, latency result, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_monitor_init    <= 1'b0;
            r_monitor_count   <= 1'b0;
            r_latency_valid   <= 1'b0;
            r_latency         <= '0;
            r_num_outstanding <= '0;
            r_overflow        <= 1'b0;
            r_underflow       <= 1'b0;
        end else if (clear) begin
            r_monitor_init    <= 1'b0;
            r_monitor_count   <= 1'b0;
            r_latency_valid   <= 1'b0;
            r_latency         <= '0;
            r_num_outstanding <= '0;
            r_overflow        <= 1'b0;
            r_underflow       <= 1'b0;
        end else begin
            r_monitor_init    <= w_pop;
            r_latency_valid   <= w_pop;
            r_monitor_count   <= enable & (w_next_count != {(AW+1){1'b0}});
            r_num_outstanding <= BW_OUTSTANDING'(w_next_count);
            if (w_pop) begin
                r_latency <= w_head_latency;
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign monitor_init    = r_monitor_init;
    assign monitor_count   = r_monitor_count;
    assign latency_valid   = r_latency_valid;
    assign latency         = r_latency;
    assign num_outstanding = r_num_outstanding;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule

// File: tb/tb_ervp_txn_latency_probe.sv
// Bench for ervp_txn_latency_probe: directed handshake sequences; expected
// latencies go into a queue and a negedge monitor compares every pulse.
module tb_ervp_txn_latency_probe;

    localparam int BW_TIME = 16;
    localparam int DEPTH   = 4;
    localparam int BW_OUT  = 3;

    logic              clk = 1'b0;
    logic              rstnn = 1'b0;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready = 1'b0;
    logic              rsp_valid = 1'b0;
    logic              rsp_ready = 1'b0;
    logic              rsp_last = 1'b0;
    logic              monitor_init;
    logic              monitor_count;
    logic              latency_valid;
    logic [BW_TIME-1:0] latency;
    logic [BW_OUT-1:0] num_outstanding;
    logic              overflow;
    logic              underflow;

    logic [15:0]       tb_ts = 16'd0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                exp_q[$];

    ervp_txn_latency_probe #(
        .BW_TIME(BW_TIME), .DEPTH(DEPTH), .BW_OUTSTANDING(BW_OUT)
    ) dut (
        .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_last(rsp_last),
        .monitor_init(monitor_init), .monitor_count(monitor_count),
        .latency_valid(latency_valid), .latency(latency),
        .num_outstanding(num_outstanding),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // one clock: inputs set now are sampled at the coming posedge
    task automatic tick;
        @(negedge clk);
        tb_ts = tb_ts + 16'd1;
    endtask

    task automatic step(input logic en, input logic clr, input logic rq,
                        input logic rv, input logic rl, input int exp_lat);
        enable    = en;
        clear     = clr;
        req_valid = rq;
        req_ready = rq;
        rsp_valid = rv;
        rsp_ready = rv;
        rsp_last  = rl;
        if (exp_lat >= 0) exp_q.push_back(exp_lat);
        tick();
    endtask

    task automatic idle;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    // scoreboard monitor: every init/valid pulse must match the next expectation
    always @(negedge clk) begin
        if (rstnn && (latency_valid || monitor_init)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: valid=%0b init=%0b latency=%0d, expected no pulse",
                         latency_valid, monitor_init, latency);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (latency_valid && monitor_init && (int'(latency) == e)) n_pass++;
                else $display("FAIL latency_pulse: valid=%0b init=%0b latency=%0d, expected 1/1/%0d",
                              latency_valid, monitor_init, latency, e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int t2_rq  [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int t2_rsp [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    int t2_exp [10] = '{-1, -1, -1, -1, -1, 5, 5, -1, -1, 7};
    int t2_cnt [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int t2_num [10] = '{1, 2, 3, 3, 3, 2, 1, 1, 1, 0};

    initial begin
        // reset values
        @(negedge clk);
        check("rst_num", num_outstanding, 0);
        check("rst_count", monitor_count, 0);
        check("rst_valid", latency_valid, 0);
        check("rst_latency", latency, 0);
        check("rst_flags", {overflow, underflow}, 0);
        @(negedge clk);
        rstnn = 1'b1;
        tb_ts = 16'd0;
        enable = 1'b1;
        repeat (10) idle();

        // single transaction, latency 7
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t1_num_after_req", num_outstanding, 1);
        check("t1_count_rise", monitor_count, 1);
        repeat (6) idle();
        check("t1_count_held", monitor_count, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7);
        check("t1_num_done", num_outstanding, 0);
        check("t1_count_fall", monitor_count, 0);
        idle();

        // pipelined: requests at 0,1,2, responses at 5,6,9
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, t2_rq[i][0], t2_rsp[i][0], t2_rsp[i][0], t2_exp[i]);
            check($sformatf("t2_count_%0d", i), monitor_count, t2_cnt[i]);
            check($sformatf("t2_num_%0d", i), num_outstanding, t2_num[i]);
        end

        // overflow: 5 requests into a 4-deep FIFO
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t3_num_full", num_outstanding, 4);
        check("t3_no_ovf_yet", overflow, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t3_num_after_5th", num_outstanding, 4);
        check("t3_ovf_set", overflow, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        check("t3_num_drained", num_outstanding, 0);
        check("t3_count_fall", monitor_count, 0);
        check("t3_ovf_sticky", overflow, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("t3_ovf_cleared", overflow, 0);

        // full with simultaneous push and pop: no overflow
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        check("t3b_num_kept", num_outstanding, 4);
        check("t3b_no_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        check("t3b_num_drained", num_outstanding, 0);

        // underflow and same-cycle push/pop on empty FIFO
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        check("t4_udf_set", underflow, 1);
        check("t4_num_empty", num_outstanding, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check("t4_push_only", num_outstanding, 1);
        check("t4_udf_sticky", underflow, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check("t4_num_done", num_outstanding, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("t4_udf_cleared", underflow, 0);

        // 3-beat response, last on 3rd beat
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        check("t5_num_mid_burst", num_outstanding, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        check("t5_num_done", num_outstanding, 0);

        // clear together with a completion, 2 outstanding
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        check("t6_udf_pre", underflow, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t6_num_two", num_outstanding, 2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        check("t6_clr_valid", latency_valid, 0);
        check("t6_clr_num", num_outstanding, 0);
        check("t6_clr_count", monitor_count, 0);
        check("t6_clr_flags", {overflow, underflow}, 0);

        // enable low during handshakes
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t7_num_one", num_outstanding, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check("t7_dis_num", num_outstanding, 1);
        check("t7_dis_count", monitor_count, 0);
        check("t7_dis_valid", latency_valid, 0);
        idle();
        check("t7_count_back", monitor_count, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        check("t7_num_done", num_outstanding, 0);

        // timestamp wrap: request at 0xFFFE, completion at 0x0003
        while (tb_ts != 16'hFFFE) idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        repeat (4) idle();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        check("t8_num_done", num_outstanding, 0);

        // asynchronous reset mid-transaction
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t9_num_two", num_outstanding, 2);
        #2;
        rstnn = 1'b0;
        #1;
        check("t9_async_num", num_outstanding, 0);
        check("t9_async_count", monitor_count, 0);
        check("t9_async_latency", latency, 0);
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        tb_ts = 16'd0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t9_num_fresh", num_outstanding, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check("t9_num_done", num_outstanding, 0);
        idle();
        idle();

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ervp_txn_latency_probe.md
Name: ervp_txn_latency_probe

Overview:
- Upstream feeder for the stall/latency watchdog monitor.
- Observes one in-order request/response channel non-intrusively and converts handshakes into the monitor's init/count strobes.
- Also measures per-transaction latency from a small FIFO of request timestamps.
- Sits beside a bus master port; outputs go to the watchdog monitor and to a debug register block.

Parameters:
- BW_TIME, 16: timestamp/latency width; latency is reported modulo 2^BW_TIME.
- DEPTH, 4: maximum tracked outstanding requests (FIFO entries); power of 2, at least 2.
- BW_OUTSTANDING, 3: width of num_outstanding; must hold DEPTH.

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- enable  in  1  probe enable; when low, no push/pop occurs and strobes are 0
- clear  in  1  synchronous flush of FIFO, counters and sticky flags
- req_valid  in  1  observed request valid
- req_ready  in  1  observed request ready
- rsp_valid  in  1  observed response valid
- rsp_ready  in  1  observed response ready
- rsp_last  in  1  last beat of response; only last beats complete a transaction
- monitor_init  out  1  one-cycle pulse per completed transaction (to monitor init)
- monitor_count  out  1  high while at least one transaction is outstanding (to monitor count)
- latency_valid  out  1  one-cycle pulse, latency is valid
- latency  out  BW_TIME  cycles from request handshake to last response handshake
- num_outstanding  out  BW_OUTSTANDING  current FIFO occupancy
- overflow  out  1  sticky; a request was accepted while the FIFO was full
- underflow  out  1  sticky; a completion occurred with the FIFO empty

Behaviour:
- Reset: every output is 0; timestamp is 0; FIFO is empty.
- Timestamp: free-running, increments every cycle regardless of enable, wraps at 2^BW_TIME.
- Push: when enable and req_valid and req_ready, write the current timestamp at the write pointer.
- Pop (completion): when enable and rsp_valid and rsp_ready and rsp_last.
  - latency is the current timestamp minus the head timestamp, modulo 2^BW_TIME.
  - latency and latency_valid are registered, so they appear in the cycle after the completion.
  - monitor_init is registered the same way and pulses in the same cycle as latency_valid.
- Non-last response beats have no effect.
- A pop sees only entries pushed in earlier cycles, so minimum latency is 1.
- Simultaneous push and pop with non-empty FIFO: both happen and occupancy is unchanged.
- Simultaneous push and pop with empty FIFO: treated as underflow (the pop is rejected); the push still happens.
- Full FIFO with a push and no pop: the request is not recorded and overflow sets.
  - Full with a simultaneous push and pop: both happen; no overflow.
- Empty FIFO with a pop: no latency_valid, no monitor_init; underflow sets.
- monitor_count is registered and equals (next occupancy != 0).
  - It rises one cycle after the first push.
  - It falls the cycle after the pop that empties the FIFO, together with the monitor_init pulse.
- num_outstanding is registered and equals FIFO occupancy.
- enable low:
  - No push, no pop.
  - monitor_init and latency_valid stay 0; monitor_count is forced to 0.
  - FIFO contents are retained.
- clear has priority over all handshakes in the same cycle. On the next edge:
  - FIFO is empty and num_outstanding is 0.
  - monitor_count is 0; overflow and underflow are 0.
  - Pending latency_valid and monitor_init are suppressed.
- clear does not reset the timestamp.
- Reset asserted mid-transaction: all state returns to reset values immediately (asynchronous); in-flight entries are lost.
- Pointers are log2(DEPTH)+1 bits, using the wrap bit to separate full from empty.

Test Plan:
- Single transaction: request handshake at T=10, last response at T=17 → at T=18 latency=7 with latency_valid=1 and monitor_init=1; monitor_count high from T=11 to T=17; num_outstanding returns to 0.
- Pipelined: requests at T=0,1,2, responses at T=5,6,9 → latencies 5,5,7 in order; num_outstanding peaks at 3; monitor_count stays high continuously until the cycle after T=9.
- Overflow: DEPTH=4, 5 back-to-back requests with no responses → num_outstanding=4, overflow=1 after the 5th request; 4 responses then give 4 valid latencies and monitor_count falls.
- Underflow plus same-cycle: response with last while FIFO empty → underflow=1 and no pulses; then request and last response in the same cycle on an empty FIFO → push only, num_outstanding=1, underflow stays 1.
- Multi-beat and wrap: 3-beat response (last on the 3rd beat) → exactly one latency_valid. Timestamp near wrap (request at 0xFFFE, completion at 0x0003 with BW_TIME=16) → latency=5.
- Clear/enable: clear in the same cycle as a completion with 2 outstanding → no latency_valid, num_outstanding=0, flags 0. enable=0 during handshakes → no state change and monitor_count=0.
